// File: rtl/cpu_stream_core.sv
// cpu_stream_core: multi-cycle stream CPU with lookup port,
// return stack, hardware loop and sticky error halt.
module cpu_stream_core #(
  parameter int N      = 8,
  parameter int NREGS  = 8,
  parameter int PSIZE  = 6,
  parameter int IMMW   = 6,
  parameter int SDEPTH = 4,
  localparam int RAW   = $clog2(NREGS),
  localparam int ISIZE = 4 + 2*RAW + IMMW
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PSIZE-1:0] pc_addr,
  input  logic [ISIZE-1:0] instr,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     lut_addr,
  input  logic [N-1:0]     lut_data,
  output logic             halted,
  output logic             error
);
  localparam int SIW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam int SPW = SIW + 1;

  typedef enum logic [2:0] {
    FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT
  } state_t;

  state_t state, state_n;

  logic [PSIZE-1:0] pc;
  logic [ISIZE-1:0] ir;
  logic [N-1:0]     rf [NREGS];
  logic [PSIZE-1:0] stk [2**SIW];
  logic [SPW-1:0]   sp;
  logic             z_q, c_q, err_q;
  logic [N-1:0]     out_q;

  logic [3:0]       op;
  logic [RAW-1:0]   rd, rs;
  logic [IMMW-1:0]  imm;
  logic [N-1:0]     a, b, imm_n, res, dec;
  logic [PSIZE-1:0] imm_p, pc_inc, pc_br;
  logic [SPW-1:0]   sp_dec;
  logic             cy, sp_full, sp_empty;
  logic             is_alu, is_arith;

  assign op     = ir[ISIZE-1 -: 4];
  assign rd     = ir[IMMW+RAW +: RAW];
  assign rs     = ir[IMMW +: RAW];
  assign imm    = ir[IMMW-1:0];
  assign a      = rf[rd];
  assign b      = rf[rs];
  assign imm_n  = N'($signed(imm));
  assign imm_p  = PSIZE'($signed(imm));
  assign dec    = a - N'(1);
  assign pc_inc = pc + PSIZE'(1);
  assign pc_br  = pc + imm_p;
  assign sp_dec = sp - SPW'(1);
  assign sp_full  = (sp == SPW'(SDEPTH));
  assign sp_empty = (sp == '0);
  assign is_alu   = (op >= 4'h1) && (op <= 4'h7);
  assign is_arith = (op >= 4'h1) && (op <= 4'h3);

  // carry and borrow both come out of the extra top bit
  always_comb begin
    res = '0;
    cy  = c_q;
    unique case (op)
      4'h1:    {cy, res} = {1'b0, a} + {1'b0, b};
      4'h2:    {cy, res} = {1'b0, a} - {1'b0, b};
      4'h3:    {cy, res} = {1'b0, a} + {1'b0, imm_n};
      4'h4:    res = a & b;
      4'h5:    res = a ^ b;
      4'h6:    res = imm_n;
      4'h7:    res = lut_data;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH: state_n = EXEC;
      EXEC: begin
        state_n = FETCH;
        unique case (1'b1)
          op == 4'h8:               state_n = WAIT_IN;
          op == 4'h9:               state_n = WAIT_OUT;
          op == 4'hF:               state_n = HALT;
          (op == 4'hC) && sp_full:  state_n = HALT;
          (op == 4'hD) && sp_empty: state_n = HALT;
          default: ;
        endcase
      end
      WAIT_IN:  if (in_valid)  state_n = FETCH;
      WAIT_OUT: if (out_ready) state_n = FETCH;
      HALT:     state_n = HALT;
      default:  state_n = FETCH;
    endcase
  end

  always_comb begin
    in_ready  = (state == WAIT_IN);
    out_valid = (state == WAIT_OUT);
    halted    = (state == HALT);
  end

  assign pc_addr  = pc;
  assign out_data = out_q;
  assign lut_addr = b;
  assign error    = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      ir    <= '0;
      sp    <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      err_q <= 1'b0;
      out_q <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      for (int i = 0; i < 2**SIW; i++) stk[i] <= '0;
    end else begin
      unique case (state)
        FETCH: ir <= instr;
        EXEC: begin
          pc <= pc_inc;
          if (is_alu) begin
            rf[rd] <= res;
            z_q    <= (res == '0);
          end
          if (is_arith) c_q <= cy;
          case (op)
            4'h8, 4'hF: pc <= pc;
            4'h9: begin
              pc    <= pc;
              out_q <= b;
            end
            4'hA: if (z_q)  pc <= pc_br;
            4'hB: if (!z_q) pc <= pc_br;
            4'hC: begin
              if (sp_full) begin
                err_q <= 1'b1;
                pc    <= pc;
              end else begin
                stk[sp[SIW-1:0]] <= pc_inc;
                sp <= sp + SPW'(1);
                pc <= pc_br;
              end
            end
            4'hD: begin
              if (sp_empty) begin
                err_q <= 1'b1;
                pc    <= pc;
              end else begin
                sp <= sp_dec;
                pc <= stk[sp_dec[SIW-1:0]];
              end
            end
            4'hE: begin
              rf[rd] <= dec;
              if (dec != '0) pc <= pc_br;
            end
            default: ;
          endcase
        end
        WAIT_IN: begin
          if (in_valid) begin
            rf[rd] <= in_data;
            z_q    <= (in_data == '0);
            pc     <= pc_inc;
          end
        end
        WAIT_OUT: if (out_ready) pc <= pc_inc;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_stream_core.sv
// tb_cpu_stream_core: directed and random programs checked
// against an instruction-level model of the core.
module tb_cpu_stream_core;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] pc_addr;
  logic [15:0] instr;
  logic [7:0] in_data, out_data, lut_addr, lut_data;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       halted, error;

  logic [15:0] prog [64];
  logic [7:0]  lut_rom [256];

  int n_assert = 0;
  int n_fail = 0;
  int m_r [8];
  int m_z, m_c, m_err, exp_pc, m_in_used;
  int exp_out [$];
  int in_q [$];

  assign instr    = prog[pc_addr];
  assign lut_data = lut_rom[lut_addr];

  always #5 clk = ~clk;

  cpu_stream_core dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .instr(instr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .halted(halted), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd,
                                      input int rs, input int imm);
    logic [15:0] w;
    w = {op[3:0], rd[2:0], rs[2:0], imm[5:0]};
    return w;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 16'hF000;
    in_q.delete();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Instruction-level interpreter of the program in prog[].
  task automatic model_run();
    int pc, op, rd, rs, imm, t, a, b, k, nxt, tgt;
    int stk [$];
    bit done;
    logic [15:0] w;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_z = 0; m_c = 0; m_err = 0; pc = 0; k = 0; done = 0;
    exp_out.delete();
    for (int s = 0; s < 5000 && !done; s++) begin
      w   = prog[pc];
      op  = int'(w[15:12]);
      rd  = int'(w[11:9]);
      rs  = int'(w[8:6]);
      imm = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
      a   = m_r[rd];
      b   = m_r[rs];
      nxt = (pc + 1) & 63;
      tgt = (pc + imm) & 63;
      pc  = nxt;
      case (op)
        1: begin t = a + b; m_c = int'(t > 255); end
        2: begin t = a - b; m_c = int'(t < 0); end
        3: begin t = a + (imm & 255); m_c = int'(t > 255); end
        4: t = a & b;
        5: t = a ^ b;
        6: t = imm;
        7: t = int'(lut_rom[b]);
        8: begin t = (k < in_q.size()) ? in_q[k] : 0; k++; end
        9: exp_out.push_back(b);
        10: if (m_z != 0) pc = tgt;
        11: if (m_z == 0) pc = tgt;
        12: begin
          if (stk.size() == 4) begin
            m_err = 1; done = 1; pc = (nxt + 63) & 63;
          end else begin
            stk.push_back(nxt); pc = tgt;
          end
        end
        13: begin
          if (stk.size() == 0) begin
            m_err = 1; done = 1; pc = (nxt + 63) & 63;
          end else pc = stk.pop_back();
        end
        14: begin
          m_r[rd] = (a - 1) & 255;
          if (m_r[rd] != 0) pc = tgt;
        end
        15: begin done = 1; pc = (nxt + 63) & 63; end
        default: ;
      endcase
      if (op >= 1 && op <= 8) begin
        m_r[rd] = t & 255;
        m_z = int'(m_r[rd] == 0);
      end
    end
    exp_pc = pc;
    m_in_used = k;
  endtask

  // Runs prog[] on the DUT with random handshake timing.
  task automatic run_prog(input string tag);
    int oi, ii, cyc;
    model_run();
    do_reset();
    oi = 0; ii = 0; cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (halted) break;
      if (out_valid) begin
        if (oi < exp_out.size())
          check({tag, "_out"}, 32'(out_data), 32'(exp_out[oi]));
        else
          check({tag, "_out_cnt"}, 32'(oi + 1), 32'(exp_out.size()));
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_ready) oi++;
      end else out_ready = 1'($urandom_range(0, 1));
      if (in_ready) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = (ii < in_q.size()) ? 8'(in_q[ii]) : 8'h00;
        if (in_valid) ii++;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(m_err));
    check({tag, "_pc"}, 32'(pc_addr), 32'(exp_pc));
    check({tag, "_nout"}, 32'(oi), 32'(exp_out.size()));
    check({tag, "_nin"}, 32'(ii), 32'(m_in_used));
    for (int i = 0; i < 8; i++)
      check({tag, "_reg"}, 32'(dut.rf[i]), 32'(m_r[i]));
    check({tag, "_z"}, 32'(dut.z_q), 32'(m_z));
    check({tag, "_c"}, 32'(dut.c_q), 32'(m_c));
  endtask

  task automatic gen_random();
    int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14};
    int op, imm;
    clear_prog();
    for (int i = 0; i < 24; i++) begin
      op  = ops[$urandom_range(0, 12)];
      imm = int'($urandom_range(0, 63));
      if (op == 10 || op == 11 || op == 14) imm = int'($urandom_range(1, 8));
      if (op == 8) in_q.push_back(int'($urandom_range(0, 255)));
      prog[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm);
    end
    for (int r = 0; r < 8; r++) prog[24 + r] = enc(9, 0, r, 0);
    prog[32] = enc(15, 0, 0, 0);
  endtask

  initial begin
    int cyc, extra;
    in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 256; i++) lut_rom[i] = 8'($urandom);
    lut_rom[8'h80] = 8'h7F;

    // Flags and two-cycle instruction timing
    clear_prog();
    prog[0] = enc(6, 1, 0, 5);
    prog[1] = enc(3, 1, 0, -5);
    prog[2] = enc(0, 0, 0, 0);
    prog[3] = enc(15, 0, 0, 0);
    do_reset();
    check("rst_pc", 32'(pc_addr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_lut_addr", 32'(lut_addr), 32'd0);
    repeat (7) @(posedge clk);
    #1;
    check("t8_early", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    check("t8_halted", 32'(halted), 32'd1);
    check("t8_pc", 32'(pc_addr), 32'd3);
    check("t8_r1", 32'(dut.rf[1]), 32'd0);
    check("t8_z", 32'(dut.z_q), 32'd1);
    check("t8_c", 32'(dut.c_q), 32'd1);

    // IN with a stalled source, OUT with a stalled sink
    clear_prog();
    prog[0] = enc(8, 2, 0, 0);
    prog[1] = enc(9, 0, 2, 0);
    do_reset();
    @(negedge clk);
    check("in_exec_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      check("in_wait_ready", 32'(in_ready), 32'd1);
      check("in_wait_pc", 32'(pc_addr), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_done_ready", 32'(in_ready), 32'd0);
    check("in_done_pc", 32'(pc_addr), 32'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("out_wait_valid", 32'(out_valid), 32'd1);
      check("out_wait_data", 32'(out_data), 32'h3C);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("out_done_valid", 32'(out_valid), 32'd0);
    check("out_done_pc", 32'(pc_addr), 32'd2);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_extra", 32'(extra), 32'd0);
    check("io_halted", 32'(halted), 32'd1);
    check("io_r2", 32'(dut.rf[2]), 32'h3C);

    // LUT lookup at 0x80
    clear_prog();
    prog[0] = enc(6, 1, 0, -32);
    prog[1] = enc(1, 1, 1, 0);
    prog[2] = enc(1, 1, 1, 0);
    prog[3] = enc(7, 5, 1, 0);
    prog[4] = enc(9, 0, 5, 0);
    prog[5] = enc(15, 0, 1, 0);
    run_prog("lut");
    check("lut_addr", 32'(lut_addr), 32'h80);

    // Async reset while OUT is waiting
    do_reset();
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("wo_valid", 32'(out_valid), 32'd1);
    check("wo_data", 32'(out_data), 32'h7F);
    #2 reset = 1'b0;
    #1;
    check("wo_rst_valid", 32'(out_valid), 32'd0);
    check("wo_rst_data", 32'(out_data), 32'd0);
    check("wo_rst_ready", 32'(in_ready), 32'd0);
    check("wo_rst_halted", 32'(halted), 32'd0);
    check("wo_rst_error", 32'(error), 32'd0);
    check("wo_rst_pc", 32'(pc_addr), 32'd0);
    check("wo_rst_lut", 32'(lut_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Hardware loop
    clear_prog();
    prog[0] = enc(6, 3, 0, 4);
    prog[1] = enc(3, 4, 0, 1);
    prog[2] = enc(14, 3, 0, -1);
    prog[3] = enc(9, 0, 4, 0);
    prog[4] = enc(9, 0, 3, 0);
    run_prog("loop");

    // Backward branch into the top of memory, straight-line wrap to 0
    clear_prog();
    prog[0]  = enc(11, 0, 0, -2);
    prog[1]  = enc(9, 0, 1, 0);
    prog[62] = enc(6, 1, 0, 1);
    prog[63] = enc(5, 0, 0, 0);
    run_prog("wrap");

    // Full-depth call chain, then overflow, then underflow
    clear_prog();
    for (int d = 0; d < 4; d++) begin
      prog[10*d]     = enc(12, 0, 0, 10);
      prog[10*d + 1] = enc(6, 1, 0, d + 1);
      prog[10*d + 2] = enc(9, 0, 1, 0);
      prog[10*d + 3] = (d == 0) ? enc(15, 0, 0, 0) : enc(13, 0, 0, 0);
    end
    prog[40] = enc(13, 0, 0, 0);
    run_prog("call");
    prog[40] = enc(12, 0, 0, 5);
    run_prog("call_ovf");
    clear_prog();
    prog[0] = enc(0, 0, 0, 0);
    prog[1] = enc(13, 0, 0, 0);
    run_prog("ret_unf");

    for (int n = 0; n < 20; n++) begin
      gen_random();
      run_prog("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
